// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI-to-RAM serial front end.
package spi_pkg;

   localparam int FRAME_W = 10;
   localparam int TX_W    = 8;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      CHK_CMD,
      WRITE,
      READ_ADD,
      READ_DATA
   } state_e;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the rx/tx handshake towards the RAM stage.
interface spi_slave_if;
   import spi_pkg::*;

   logic               SS_n;
   logic               MOSI;
   logic               MISO;
   logic [TX_W-1:0]    tx_data;
   logic               tx_valid;
   logic [FRAME_W-1:0] rx_data;
   logic               rx_valid;

   modport slave  (input  SS_n, MOSI, tx_data, tx_valid,
                   output MISO, rx_data, rx_valid);
   modport master (output SS_n, MOSI, tx_data, tx_valid,
                   input  MISO, rx_data, rx_valid);
endinterface

// File: rtl/spi_miso_ser.sv
// MISO serializer: arms on a read-data frame, captures the first tx_valid
// byte and shifts it out MSB first over 8 cycles.
module spi_miso_ser
   import spi_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_abort,
   input  logic            i_start,
   input  logic            i_tx_valid,
   input  logic [TX_W-1:0] i_tx_data,
   output logic            o_miso,
   output logic            o_done
);

   logic [TX_W-1:0] r_sh;
   logic [2:0]      r_cnt;
   logic            r_wait;
   logic            r_busy;
   logic            r_miso;

   always_ff @(posedge clk) begin
      if (!rst_n || i_abort) begin
         r_sh   <= '0;
         r_cnt  <= '0;
         r_wait <= 1'b0;
         r_busy <= 1'b0;
         r_miso <= 1'b0;
      end else if (i_start) begin
         r_wait <= 1'b1;
      end else if (r_wait && i_tx_valid) begin
         // MSB goes straight to the pin; the latch keeps the rest pre-shifted
         r_wait <= 1'b0;
         r_busy <= 1'b1;
         r_cnt  <= '0;
         r_miso <= i_tx_data[TX_W-1];
         r_sh   <= {i_tx_data[TX_W-2:0], 1'b0};
      end else if (r_busy) begin
         r_cnt  <= r_cnt + 3'd1;
         r_miso <= r_sh[TX_W-1];
         r_sh   <= {r_sh[TX_W-2:0], 1'b0};
         if (r_cnt == 3'd7)
            r_busy <= 1'b0;
      end
   end

   assign o_miso = r_miso;
   assign o_done = r_busy && (r_cnt == 3'd7) && !i_abort;

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end: frame FSM and receive shifter, feeding rx_data/rx_valid
// to the RAM stage and serializing its read reply on MISO.
module spi_slave
   import spi_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   spi_slave_if.slave  bus
);

   localparam logic [3:0] LAST_BIT = 4'(FRAME_W - 1);

   state_e             r_state;
   state_e             w_next;
   logic [3:0]         r_bit_cnt;
   logic [FRAME_W-2:0] r_shift;
   logic [FRAME_W-1:0] w_shift_nx;
   logic [FRAME_W-1:0] r_rx_data;
   logic               r_rx_valid;
   logic               r_frame_done;
   logic               r_rd_addr_seen;
   logic               w_rx_phase;
   logic               w_start;
   logic               w_ser_done;
   logic               w_miso;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (!bus.SS_n) w_next = CHK_CMD;
         CHK_CMD: begin
            if (bus.SS_n)          w_next = IDLE;
            else if (!bus.MOSI)    w_next = WRITE;
            else if (r_rd_addr_seen) w_next = READ_DATA;
            else                   w_next = READ_ADD;
         end
         default: if (bus.SS_n) w_next = IDLE;
      endcase
   end

   assign w_rx_phase = (r_state inside {WRITE, READ_ADD, READ_DATA}) && !bus.SS_n;
   // Only 9 bits need storing: the 10th arrives on the cycle the word is loaded
   assign w_shift_nx = {r_shift, bus.MOSI};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bit_cnt      <= '0;
         r_shift        <= '0;
         r_rx_data      <= '0;
         r_rx_valid     <= 1'b0;
         r_frame_done   <= 1'b0;
         r_rd_addr_seen <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         if (!w_rx_phase) begin
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_frame_done <= 1'b0;
         end else if (!r_frame_done) begin
            r_shift <= w_shift_nx[FRAME_W-2:0];
            if (r_bit_cnt == LAST_BIT) begin
               r_rx_data    <= w_shift_nx;
               r_rx_valid   <= 1'b1;
               r_frame_done <= 1'b1;
               if (r_state == READ_ADD)
                  r_rd_addr_seen <= 1'b1;
            end else begin
               r_bit_cnt <= r_bit_cnt + 4'd1;
            end
         end
         if (w_ser_done)
            r_rd_addr_seen <= 1'b0;
      end
   end

   assign w_start = r_rx_valid && (r_state == READ_DATA);

   spi_miso_ser u_miso_ser (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_abort    (bus.SS_n),
      .i_start    (w_start),
      .i_tx_valid (bus.tx_valid),
      .i_tx_data  (bus.tx_data),
      .o_miso     (w_miso),
      .o_done     (w_ser_done)
   );

   assign bus.MISO     = w_miso;
   assign bus.rx_data  = r_rx_data;
   assign bus.rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave.sv
// Frame-level stimulus and expected-output timelines for spi_slave, built up
// front from the frame timing rules, then replayed and compared every cycle.
module tb_spi_slave;
   import spi_pkg::*;

   localparam int N = 4000;

   logic clk;
   logic rst_n;
   spi_slave_if bus();

   spi_slave dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b1;
      forever begin
         #5 clk = 1'b0;
         #5 clk = 1'b1;
      end
   end

   // stimulus for cycle c is applied before the rising edge that ends cycle c;
   // expected outputs for cycle c are the values visible during cycle c
   logic       s_rst [N];
   logic       s_ss  [N];
   logic       s_mosi[N];
   logic       s_txv [N];
   logic [7:0] s_txd [N];
   logic       e_miso[N];
   logic       e_rxv [N];
   logic       e_chk [N];
   logic [9:0] e_rxd [N];
   logic       ev_v  [N];
   logic [9:0] ev_d  [N];
   logic       g_miso[N];
   logic       g_rxv [N];
   logic [9:0] g_rxd [N];

   int cur;
   int cyc;
   int last;
   int n_chk;
   int n_err;
   bit m_seen;
   bit run_done;

   task automatic check(input string nm, input int c, input logic [9:0] got,
                        input logic [9:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, c, got, exp);
      end
   endtask

   // One frame starting with SS_n low at cycle cur. nbits<10 aborts after that
   // many payload bits. Read-data replies: tx_valid first at rx_valid+txv_off.
   task automatic frame(input bit mode, input logic [9:0] d, input int nbits,
                        input int txv_off, input int txv_len,
                        input logic [7:0] b0, input logic [7:0] b1,
                        input int cut, input int rst_at, input int extra,
                        output int rxv_cyc, output int k_cyc);
      int t0;
      int k;
      bit rd;
      t0 = cur;
      rxv_cyc = -1;
      k_cyc = -1;
      s_ss[t0] = 1'b0;
      s_ss[t0+1] = 1'b0;
      s_mosi[t0+1] = mode;
      for (int i = 0; i < nbits; i++) begin
         s_ss[t0+2+i] = 1'b0;
         s_mosi[t0+2+i] = d[9-i];
      end
      if (nbits < FRAME_W) begin
         cur = t0 + 3 + nbits;
         return;
      end
      rxv_cyc = t0 + 12;
      e_rxv[t0+12] = 1'b1;
      ev_v[t0+12] = 1'b1;
      ev_d[t0+12] = d;
      rd = mode && m_seen;
      if (mode && !m_seen) m_seen = 1'b1;
      if (!rd) begin
         for (int c = t0 + 12; c <= t0 + 12 + extra; c++) s_ss[c] = 1'b0;
         cur = t0 + 14 + extra;
         return;
      end
      k = t0 + 12 + txv_off;
      k_cyc = k;
      for (int c = t0; c < k; c++) s_txv[c] = 1'b0;
      for (int c = k; c < k + txv_len; c++) begin
         s_txv[c] = 1'b1;
         s_txd[c] = (c == k) ? b0 : b1;
      end
      for (int c = t0 + 12; c < k; c++) s_ss[c] = 1'b0;
      if (cut > 0) begin
         for (int c = k; c < k + cut; c++) s_ss[c] = 1'b0;
         for (int j = 0; j < cut; j++) e_miso[k+1+j] = b0[7-j];
         cur = k + cut + 1;
         return;
      end
      if (rst_at > 0) begin
         for (int c = k; c < k + rst_at; c++) s_ss[c] = 1'b0;
         s_rst[k+rst_at] = 1'b0;
         s_rst[k+rst_at+1] = 1'b0;
         for (int j = 0; j < rst_at; j++) e_miso[k+1+j] = b0[7-j];
         ev_v[k+rst_at+1] = 1'b1;
         ev_d[k+rst_at+1] = '0;
         m_seen = 1'b0;
         cur = k + rst_at + 2;
         return;
      end
      for (int c = k; c <= k + 8 + extra; c++) s_ss[c] = 1'b0;
      for (int j = 0; j < 8; j++) e_miso[k+1+j] = b0[7-j];
      m_seen = 1'b0;
      cur = k + 10 + extra;
   endtask

   function automatic logic [7:0] reply_at(input int k);
      logic [7:0] b;
      for (int j = 0; j < 8; j++) b[7-j] = g_miso[k+1+j];
      return b;
   endfunction

   always @(negedge clk) begin
      if (!run_done && e_chk[cyc]) begin
         g_miso[cyc] = bus.MISO;
         g_rxv[cyc]  = bus.rx_valid;
         g_rxd[cyc]  = bus.rx_data;
         check("MISO", cyc, {9'd0, bus.MISO}, {9'd0, e_miso[cyc]});
         check("rx_valid", cyc, {9'd0, bus.rx_valid}, {9'd0, e_rxv[cyc]});
         check("rx_data", cyc, bus.rx_data, e_rxd[cyc]);
      end
   end

   initial begin
      int wa_rv, wd_rv, ra_rv, c3_k, ab_t0, ps_k, ct_k, rs_rv, rv, kk;
      int mode, nb, cut;
      logic [1:0] cmd;
      logic [9:0] h;
      logic any_rxv;

      n_chk = 0;
      n_err = 0;
      cyc = 0;
      run_done = 1'b0;
      m_seen = 1'b0;
      for (int c = 0; c < N; c++) begin
         s_rst[c] = 1'b1;
         s_ss[c] = 1'b1;
         s_mosi[c] = 1'($urandom);
         s_txv[c] = 1'($urandom);
         s_txd[c] = 8'($urandom);
         e_miso[c] = 1'b0;
         e_rxv[c] = 1'b0;
         e_chk[c] = 1'b0;
         ev_v[c] = 1'b0;
         ev_d[c] = '0;
         g_miso[c] = 1'b0;
         g_rxv[c] = 1'b0;
         g_rxd[c] = '0;
      end
      for (int c = 0; c < 3; c++) s_rst[c] = 1'b0;
      ev_v[1] = 1'b1;
      cur = 5;

      frame(1'b0, 10'h0A5, 10, 1, 1, 8'h00, 8'h00, 0, 0, 0, wa_rv, kk);
      cur += 1;
      frame(1'b0, 10'h13C, 10, 1, 1, 8'h00, 8'h00, 0, 0, 2, wd_rv, kk);
      frame(1'b1, 10'h207, 10, 1, 1, 8'h00, 8'h00, 0, 0, 0, ra_rv, kk);
      frame(1'b1, {CMD_RD_DATA, 8'h5E}, 10, 1, 1, 8'hC3, 8'h00, 0, 0, 0, rv, c3_k);
      ab_t0 = cur;
      frame(1'b0, {CMD_WR_DATA, 8'h3D}, 5, 1, 1, 8'h00, 8'h00, 0, 0, 0, rv, kk);
      frame(1'b0, 10'h1E1, 10, 1, 1, 8'h00, 8'h00, 0, 0, 1, rv, kk);
      frame(1'b1, 10'h2AA, 10, 1, 1, 8'h00, 8'h00, 0, 0, 0, rv, kk);
      frame(1'b1, {CMD_RD_DATA, 8'h11}, 10, 1, 9, 8'h5A, 8'hA5, 0, 0, 0, rv, ps_k);
      frame(1'b1, 10'h2CC, 10, 1, 1, 8'h00, 8'h00, 0, 0, 0, rv, kk);
      frame(1'b1, {CMD_RD_DATA, 8'h22}, 10, 2, 1, 8'h77, 8'h00, 4, 0, 0, rv, kk);
      frame(1'b1, {CMD_RD_DATA, 8'h33}, 10, 1, 1, 8'h96, 8'h00, 0, 0, 0, rv, ct_k);
      frame(1'b1, 10'h2DD, 10, 1, 1, 8'h00, 8'h00, 0, 0, 0, rv, kk);
      frame(1'b1, {CMD_RD_DATA, 8'h44}, 10, 1, 1, 8'hE7, 8'h00, 0, 3, 0, rv, kk);
      frame(1'b1, 10'h3F0, 10, 1, 1, 8'h00, 8'h00, 0, 0, 10, rs_rv, kk);
      s_txv[rs_rv+1] = 1'b1;
      s_txd[rs_rv+1] = 8'hFF;
      cur += 1;

      for (int i = 0; i < 40; i++) begin
         mode = int'($urandom_range(0, 1));
         if (mode != 0) cmd = m_seen ? CMD_RD_DATA : CMD_RD_ADDR;
         else           cmd = ($urandom_range(0, 1) != 0) ? CMD_WR_DATA : CMD_WR_ADDR;
         nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : 10;
         cut = 0;
         if (mode != 0 && m_seen && $urandom_range(0, 5) == 0) cut = int'($urandom_range(1, 7));
         frame(1'(mode), {cmd, 8'($urandom)}, nb, int'($urandom_range(1, 4)),
               int'($urandom_range(1, 9)), 8'($urandom), 8'($urandom), cut, 0,
               int'($urandom_range(0, 3)), rv, kk);
         cur += int'($urandom_range(0, 2));
      end

      last = cur + 2;
      h = '0;
      for (int c = 0; c <= last; c++) begin
         if (ev_v[c]) h = ev_d[c];
         e_rxd[c] = h;
         e_chk[c] = (c >= 1);
      end

      #1;
      for (int c = 0; c <= last; c++) begin
         cyc = c;
         rst_n = s_rst[c];
         bus.SS_n = s_ss[c];
         bus.MOSI = s_mosi[c];
         bus.tx_valid = s_txv[c];
         bus.tx_data = s_txd[c];
         @(posedge clk);
         #1;
      end
      run_done = 1'b1;

      // hand-computed anchors for the directed frames
      check("wr_addr_pulse", wa_rv, {9'd0, g_rxv[wa_rv]}, 10'd1);
      check("wr_addr_data", wa_rv, g_rxd[wa_rv], 10'h0A5);
      check("wr_addr_single", wa_rv + 1, {9'd0, g_rxv[wa_rv+1]}, 10'd0);
      check("wr_data_data", wd_rv, g_rxd[wd_rv], 10'h13C);
      check("rd_addr_data", ra_rv, g_rxd[ra_rv], 10'h207);
      check("rd_reply_C3", c3_k, {2'd0, reply_at(c3_k)}, 10'h0C3);
      check("rd_reply_tail", c3_k + 9, {9'd0, g_miso[c3_k+9]}, 10'd0);
      any_rxv = 1'b0;
      for (int c = ab_t0; c < ab_t0 + 16; c++) any_rxv |= g_rxv[c];
      check("abort_no_pulse", ab_t0, {9'd0, any_rxv}, 10'd0);
      check("persist_first", ps_k, {2'd0, reply_at(ps_k)}, 10'h05A);
      check("after_cut_reply", ct_k, {2'd0, reply_at(ct_k)}, 10'h096);
      check("post_rst_no_reply", rs_rv + 1, {2'd0, reply_at(rs_rv + 1)}, 10'h000);
      check("post_rst_data", rs_rv, g_rxd[rs_rv], 10'h3F0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
